instr_decode: RTL and testbench

INSTR_DECODE -- requirements
Module: instr_decode

---
 rtl/instr_decode_if.sv | 33 +++
 rtl/instr_decode.sv | 161 ++++++++++++++++
 tb/tb_instr_decode.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/instr_decode_if.sv
// Decode-stage bus: fetched word plus pipeline controls in, registered control bundle out.
// The slave modport is the decoder; the master modport is whatever feeds and consumes it.
interface instr_decode_if;
  logic [15:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        flush;
  logic        out_valid;
  logic        alu_en;
  logic [3:0]  alu_op;
  logic [3:0]  shamt;
  logic [2:0]  rsrc;
  logic [2:0]  rdst;
  logic [15:0] imm;
  logic        use_imm;
  logic        reg_wr;
  logic        mem_rd;
  logic        mem_wr;
  logic        flag_wr;
  logic        illegal;

  modport master (
    output instr, instr_valid, stall, flush,
    input  out_valid, alu_en, alu_op, shamt, rsrc, rdst, imm, use_imm,
           reg_wr, mem_rd, mem_wr, flag_wr, illegal
  );

  modport slave (
    input  instr, instr_valid, stall, flush,
    output out_valid, alu_en, alu_op, shamt, rsrc, rdst, imm, use_imm,
           reg_wr, mem_rd, mem_wr, flag_wr, illegal
  );
endinterface

// File: rtl/instr_decode.sv
// 16-bit instruction decoder with a two-word LDM sequence (opcode word, then immediate word).
// Every output comes straight from a register; stall freezes everything, flush inserts a bubble.
module instr_decode (
  input  logic           clk,
  input  logic           rst,
  instr_decode_if.slave  bus
);

  typedef enum logic {FIRST, IMM} state_t;

  typedef struct packed {
    logic        out_valid;
    logic        alu_en;
    logic [3:0]  alu_op;
    logic [3:0]  shamt;
    logic [2:0]  rsrc;
    logic [2:0]  rdst;
    logic [15:0] imm;
    logic        use_imm;
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
    logic        flag_wr;
    logic        illegal;
  } bundle_t;

  localparam logic [4:0] OP_LDM = 5'b01101;

  localparam logic [3:0] ALU_INC  = 4'b0000;
  localparam logic [3:0] ALU_DEC  = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_MOV  = 4'b0100;
  localparam logic [3:0] ALU_NOT  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SHL  = 4'b1000;
  localparam logic [3:0] ALU_SHR  = 4'b1001;
  localparam logic [3:0] ALU_SETC = 4'b1010;
  localparam logic [3:0] ALU_CLC  = 4'b1011;

  state_t  state_q, state_d;
  bundle_t out_q, out_d;
  logic [2:0] ldm_rsrc_q, ldm_rsrc_d;
  logic [2:0] ldm_rdst_q, ldm_rdst_d;

  // Single-word decode; LDM is assembled separately once its immediate arrives.
  function automatic bundle_t decode(input logic [15:0] w);
    bundle_t b;
    b           = '0;
    b.out_valid = 1'b1;
    b.alu_en    = 1'b1;
    b.rsrc      = w[10:8];
    b.rdst      = w[7:5];
    unique case (w[15:11])
      5'b00001: begin b.alu_op = ALU_SETC; b.flag_wr = 1'b1; end
      5'b00010: begin b.alu_op = ALU_CLC;  b.flag_wr = 1'b1; end
      5'b00011: begin b.alu_op = ALU_NOT;  b.reg_wr = 1'b1; b.flag_wr = 1'b1; end
      5'b00100: begin b.alu_op = ALU_INC;  b.reg_wr = 1'b1; b.flag_wr = 1'b1; end
      5'b00101: begin b.alu_op = ALU_DEC;  b.reg_wr = 1'b1; b.flag_wr = 1'b1; end
      5'b00110: begin b.alu_op = ALU_MOV;  b.reg_wr = 1'b1; end
      5'b00111: begin b.alu_op = ALU_ADD;  b.reg_wr = 1'b1; b.flag_wr = 1'b1; end
      5'b01000: begin b.alu_op = ALU_SUB;  b.reg_wr = 1'b1; b.flag_wr = 1'b1; end
      5'b01001: begin b.alu_op = ALU_AND;  b.reg_wr = 1'b1; b.flag_wr = 1'b1; end
      5'b01010: begin b.alu_op = ALU_OR;   b.reg_wr = 1'b1; b.flag_wr = 1'b1; end
      5'b01011: begin
        b.alu_op = ALU_SHL; b.shamt = w[4:1]; b.reg_wr = 1'b1; b.flag_wr = 1'b1;
      end
      5'b01100: begin
        b.alu_op = ALU_SHR; b.shamt = w[4:1]; b.reg_wr = 1'b1; b.flag_wr = 1'b1;
      end
      5'b01110: begin b.alu_en = 1'b0; b.mem_rd = 1'b1; b.reg_wr = 1'b1; end
      5'b01111: begin b.alu_en = 1'b0; b.mem_wr = 1'b1; end
      5'b00000: begin
        b           = '0;
        b.out_valid = 1'b1;
      end
      default: begin
        // Undefined opcodes still occupy a slot so the trap logic downstream sees them.
        b           = '0;
        b.out_valid = 1'b1;
        b.illegal   = 1'b1;
      end
    endcase
    return b;
  endfunction

  // NOTE: every variable driven here gets a default first so no latch can be inferred.
  always_comb begin
    state_d    = state_q;
    out_d      = '0;
    ldm_rsrc_d = ldm_rsrc_q;
    ldm_rdst_d = ldm_rdst_q;

    if (bus.flush) begin
      state_d    = FIRST;
      ldm_rsrc_d = '0;
      ldm_rdst_d = '0;
    end else if (bus.stall) begin
      out_d = out_q;
    end else begin
      unique case (state_q)
        FIRST: begin
          if (bus.instr_valid) begin
            if (bus.instr[15:11] == OP_LDM) begin
              ldm_rsrc_d = bus.instr[10:8];
              ldm_rdst_d = bus.instr[7:5];
              state_d    = IMM;
            end else begin
              out_d = decode(bus.instr);
            end
          end
        end
        IMM: begin
          if (bus.instr_valid) begin
            out_d.out_valid = 1'b1;
            out_d.alu_en    = 1'b1;
            out_d.alu_op    = ALU_MOV;
            out_d.rsrc      = ldm_rsrc_q;
            out_d.rdst      = ldm_rdst_q;
            out_d.imm       = bus.instr;
            out_d.use_imm   = 1'b1;
            out_d.reg_wr    = 1'b1;
            state_d         = FIRST;
          end
        end
        default: state_d = FIRST;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FIRST;
      out_q      <= '0;
      ldm_rsrc_q <= '0;
      ldm_rdst_q <= '0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      ldm_rsrc_q <= ldm_rsrc_d;
      ldm_rdst_q <= ldm_rdst_d;
    end
  end

  assign bus.out_valid = out_q.out_valid;
  assign bus.alu_en    = out_q.alu_en;
  assign bus.alu_op    = out_q.alu_op;
  assign bus.shamt     = out_q.shamt;
  assign bus.rsrc      = out_q.rsrc;
  assign bus.rdst      = out_q.rdst;
  assign bus.imm       = out_q.imm;
  assign bus.use_imm   = out_q.use_imm;
  assign bus.reg_wr    = out_q.reg_wr;
  assign bus.mem_rd    = out_q.mem_rd;
  assign bus.mem_wr    = out_q.mem_wr;
  assign bus.flag_wr   = out_q.flag_wr;
  assign bus.illegal   = out_q.illegal;

endmodule

// File: tb/tb_instr_decode.sv
// Scoreboard bench for instr_decode: each driven cycle queues the hand-computed bundle
// expected after that edge; a monitor on the falling edge pops and compares it.
module tb_instr_decode;

  typedef struct packed {
    logic        out_valid;
    logic        alu_en;
    logic [3:0]  alu_op;
    logic [3:0]  shamt;
    logic [2:0]  rsrc;
    logic [2:0]  rdst;
    logic [15:0] imm;
    logic        use_imm;
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
    logic        flag_wr;
    logic        illegal;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  string name_q[$];

  instr_decode_if bus ();

  instr_decode dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t b(input logic v, input logic en, input logic [3:0] op,
                             input logic [3:0] sh, input logic [2:0] rs, input logic [2:0] rd,
                             input logic [15:0] imm, input logic ui, input logic rw,
                             input logic mr, input logic mw, input logic fw, input logic il);
    exp_t e;
    e = '{v, en, op, sh, rs, rd, imm, ui, rw, mr, mw, fw, il};
    return e;
  endfunction

  function automatic exp_t zero();
    return '0;
  endfunction

  // One cycle of stimulus, applied just after the falling edge so it is stable at the rising edge.
  task automatic drive(input string nm, input logic r, input logic iv, input logic [15:0] w,
                       input logic st, input logic fl, input exp_t e);
    @(negedge clk);
    #1;
    rst             = r;
    bus.instr_valid = iv;
    bus.instr       = w;
    bus.stall       = st;
    bus.flush       = fl;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic check(input string nm, input exp_t act, input exp_t e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, e);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the oldest queued expectation.
  initial begin
    exp_t act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        act = '{bus.out_valid, bus.alu_en, bus.alu_op, bus.shamt, bus.rsrc, bus.rdst,
                bus.imm, bus.use_imm, bus.reg_wr, bus.mem_rd, bus.mem_wr, bus.flag_wr,
                bus.illegal};
        check(name_q.pop_front(), act, exp_q.pop_front());
      end
    end
  end

  initial begin
    exp_t add_b;
    int   wait_cycles;
    add_b = b(1, 1, 4'h2, 4'h0, 3'd5, 3'd0, 16'h0, 0, 1, 0, 0, 1, 0);

    bus.instr       = '0;
    bus.instr_valid = 1'b0;
    bus.stall       = 1'b0;
    bus.flush       = 1'b0;

    drive("reset",      1, 0, 16'h0000, 0, 0, zero());
    drive("idle",       0, 0, 16'h0000, 0, 0, zero());

    drive("add",        0, 1, 16'h3D00, 0, 0, add_b);
    drive("shl",        0, 1, 16'h5812, 0, 0, b(1, 1, 4'h8, 4'h9, 3'd0, 3'd0, 16'h0, 0, 1, 0, 0, 1, 0));
    drive("shr",        0, 1, 16'h63CA, 0, 0, b(1, 1, 4'h9, 4'h5, 3'd3, 3'd6, 16'h0, 0, 1, 0, 0, 1, 0));
    drive("setc",       0, 1, 16'h0FFE, 0, 0, b(1, 1, 4'hA, 4'h0, 3'd7, 3'd7, 16'h0, 0, 0, 0, 0, 1, 0));
    drive("clc",        0, 1, 16'h1000, 0, 0, b(1, 1, 4'hB, 4'h0, 3'd0, 3'd0, 16'h0, 0, 0, 0, 0, 1, 0));
    drive("not",        0, 1, 16'h1C40, 0, 0, b(1, 1, 4'h5, 4'h0, 3'd4, 3'd2, 16'h0, 0, 1, 0, 0, 1, 0));
    drive("inc",        0, 1, 16'h2000, 0, 0, b(1, 1, 4'h0, 4'h0, 3'd0, 3'd0, 16'h0, 0, 1, 0, 0, 1, 0));
    drive("dec",        0, 1, 16'h2800, 0, 0, b(1, 1, 4'h1, 4'h0, 3'd0, 3'd0, 16'h0, 0, 1, 0, 0, 1, 0));
    drive("mov",        0, 1, 16'h3000, 0, 0, b(1, 1, 4'h4, 4'h0, 3'd0, 3'd0, 16'h0, 0, 1, 0, 0, 0, 0));
    drive("sub",        0, 1, 16'h4620, 0, 0, b(1, 1, 4'h3, 4'h0, 3'd6, 3'd1, 16'h0, 0, 1, 0, 0, 1, 0));
    drive("and",        0, 1, 16'h4800, 0, 0, b(1, 1, 4'h7, 4'h0, 3'd0, 3'd0, 16'h0, 0, 1, 0, 0, 1, 0));
    drive("or",         0, 1, 16'h5000, 0, 0, b(1, 1, 4'h6, 4'h0, 3'd0, 3'd0, 16'h0, 0, 1, 0, 0, 1, 0));
    drive("ldd",        0, 1, 16'h7280, 0, 0, b(1, 0, 4'h0, 4'h0, 3'd2, 3'd4, 16'h0, 0, 1, 1, 0, 0, 0));
    drive("std",        0, 1, 16'h7960, 0, 0, b(1, 0, 4'h0, 4'h0, 3'd1, 3'd3, 16'h0, 0, 0, 0, 1, 0, 0));
    drive("nop",        0, 1, 16'h07FE, 0, 0, b(1, 0, 4'h0, 4'h0, 3'd0, 3'd0, 16'h0, 0, 0, 0, 0, 0, 0));
    drive("illegal_lo", 0, 1, 16'h87FF, 0, 0, b(1, 0, 4'h0, 4'h0, 3'd0, 3'd0, 16'h0, 0, 0, 0, 0, 0, 1));
    drive("bubble",     0, 0, 16'h3D00, 0, 0, zero());

    // LDM with idle gap before the immediate word.
    drive("ldm_w1",     0, 1, 16'h68E0, 0, 0, zero());
    drive("ldm_gap1",   0, 0, 16'h0000, 0, 0, zero());
    drive("ldm_gap2",   0, 0, 16'h0000, 0, 0, zero());
    drive("ldm_imm",    0, 1, 16'hBEEF, 0, 0, b(1, 1, 4'h4, 4'h0, 3'd0, 3'd7, 16'hBEEF, 1, 1, 0, 0, 0, 0));

    // Stall freezes a decoded bundle; flush beats stall.
    drive("stall_add",  0, 1, 16'h3D00, 0, 0, add_b);
    for (int i = 0; i < 3; i++)
      drive($sformatf("stall_hold%0d", i), 0, 1, 16'h5812, 1, 0, add_b);
    drive("flush_stall", 0, 1, 16'h5812, 1, 1, zero());
    drive("after_flush", 0, 1, 16'h7280, 0, 0, b(1, 0, 4'h0, 4'h0, 3'd2, 3'd4, 16'h0, 0, 1, 1, 0, 0, 0));

    // Stall in IMM must not consume the word presented meanwhile.
    drive("ldm2_w1",    0, 1, 16'h68E0, 0, 0, zero());
    drive("ldm2_stall", 0, 1, 16'h1234, 1, 0, zero());
    drive("ldm2_imm",   0, 1, 16'h0042, 0, 0, b(1, 1, 4'h4, 4'h0, 3'd0, 3'd7, 16'h0042, 1, 1, 0, 0, 0, 0));

    // Flush abandons a pending LDM.
    drive("ldm3_w1",    0, 1, 16'h68E0, 0, 0, zero());
    drive("ldm3_flush", 0, 1, 16'h1111, 0, 1, zero());
    drive("post_flush", 0, 1, 16'hF800, 0, 0, b(1, 0, 4'h0, 4'h0, 3'd0, 3'd0, 16'h0, 0, 0, 0, 0, 0, 1));

    // Reset abandons a pending LDM too.
    drive("ldm4_w1",    0, 1, 16'h68E0, 0, 0, zero());
    drive("ldm4_rst",   1, 1, 16'hBEEF, 1, 1, zero());
    drive("post_rst",   0, 1, 16'hF800, 0, 0, b(1, 0, 4'h0, 4'h0, 3'd0, 3'd0, 16'h0, 0, 0, 0, 0, 0, 1));
    drive("final_idle", 0, 0, 16'h0000, 0, 0, zero());

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    @(negedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
